// File: rtl/pipe_track_pkg.sv
// rtl/pipe_track_pkg.sv - shared constants, slot type and BCD helper for the pipe track
package pipe_track_pkg;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Slot field widths; the track engine checks its X_W/GAP_W against these.
  localparam int SLOT_X_W       = 11;
  localparam int SLOT_GAP_W     = 2;
  localparam int BCD_MAX_DIGITS = 8;

  typedef struct packed {
    logic [SLOT_X_W-1:0]   x;
    logic [SLOT_GAP_W-1:0] gap;
  } pipe_slot_t;

  // Add one to the low n BCD digits; returns {carry_out_of_top_digit, next_digits}.
  function automatic logic [4*BCD_MAX_DIGITS:0] bcd_inc(input logic [4*BCD_MAX_DIGITS-1:0] digits,
                                                        input int n);
    logic [4*BCD_MAX_DIGITS-1:0] nxt;
    logic                        carry;
    nxt   = digits;
    carry = 1'b1;
    for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
      if ((d < n) && carry) begin
        if (digits[4*d +: 4] == 4'd9) begin
          nxt[4*d +: 4] = 4'd0;
        end else begin
          nxt[4*d +: 4] = digits[4*d +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return {carry, nxt};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR with synchronous reload and step enable
module lfsr16
  import pipe_track_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  // Reload wins over advance so a restart always begins from the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/pipe_track_ram.sv
// rtl/pipe_track_ram.sv - scrolling pipe slots, respawn, BCD score and registered read port
module pipe_track_ram
  import pipe_track_pkg::*;
#(
  parameter int N_PIPES      = 4,
  parameter int X_W          = 11,
  parameter int SCREEN_W     = 640,
  parameter int PIPE_SPACING = 180,
  parameter int PIPE_W       = 40,
  parameter int BIRD_X       = 160,
  parameter int SPEED        = 2,
  parameter int DIV_MAX      = 4,
  parameter int GAP_W        = 2,
  parameter int SCORE_DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      count_EN,
  input  logic                      clear,
  input  logic [$clog2(N_PIPES):0]  rd_idx,
  output logic [X_W-1:0]            rd_x,
  output logic [GAP_W-1:0]          rd_gap,
  output logic                      rd_valid,
  output logic                      step,
  output logic [4*SCORE_DIGITS-1:0] Score,
  output logic                      score_wrap
);

  localparam int IDX_W   = $clog2(N_PIPES);
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int SCORE_W = 4 * SCORE_DIGITS;
  localparam int BCD_W   = 4 * BCD_MAX_DIGITS;

  // x arithmetic runs one bit wider than storage so the respawn add cannot wrap early.
  localparam logic [X_W:0]       SPEED_X     = (X_W+1)'(SPEED);
  localparam logic [X_W:0]       RESPAWN_ADD = (X_W+1)'(N_PIPES * PIPE_SPACING - SPEED);
  localparam logic [X_W:0]       PIPE_W_X    = (X_W+1)'(PIPE_W);
  localparam logic [X_W:0]       BIRD_X_X    = (X_W+1)'(BIRD_X);
  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(DIV_MAX - 1);
  localparam logic [IDX_W:0]     N_PIPES_IDX = (IDX_W+1)'(N_PIPES);

  if (N_PIPES < 2 || (N_PIPES & (N_PIPES - 1)) != 0) begin : g_chk_npipes
    $error("pipe_track_ram: N_PIPES must be a power of 2 and at least 2");
  end
  if (N_PIPES * PIPE_SPACING < SCREEN_W + PIPE_W) begin : g_chk_span
    $error("pipe_track_ram: N_PIPES*PIPE_SPACING must be at least SCREEN_W + PIPE_W");
  end
  if (SCREEN_W + N_PIPES * PIPE_SPACING >= (1 << X_W)) begin : g_chk_xw
    $error("pipe_track_ram: SCREEN_W + N_PIPES*PIPE_SPACING must fit in X_W bits");
  end
  if (X_W != SLOT_X_W || GAP_W != SLOT_GAP_W || SCORE_DIGITS > BCD_MAX_DIGITS) begin : g_chk_slot
    $error("pipe_track_ram: X_W/GAP_W/SCORE_DIGITS do not match the package slot and BCD sizes");
  end
  if (PIPE_SPACING <= SPEED) begin : g_chk_speed
    $error("pipe_track_ram: PIPE_SPACING must exceed SPEED");
  end

  pipe_slot_t         slot_q [N_PIPES];
  pipe_slot_t         slot_d [N_PIPES];
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;
  logic [X_W-1:0]     rd_x_q;
  logic [GAP_W-1:0]   rd_gap_q;
  logic               rd_valid_q;
  logic               rd_hit;
  logic               any_respawn;
  logic               crossing;
  logic [15:0]        lfsr_q;
  logic [BCD_W:0]     inc_res;
  logic               unused_bits;

  function automatic pipe_slot_t init_slot(input int i);
    pipe_slot_t s;
    s.x   = X_W'(SCREEN_W + i * PIPE_SPACING);
    s.gap = GAP_W'(i);
    return s;
  endfunction

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(reset),
    .en   (step_d && any_respawn),
    .load (clear),
    .q    (lfsr_q)
  );

  assign step_d      = count_EN && (div_q == DIV_LAST);
  assign div_d       = !count_EN ? div_q : ((div_q == DIV_LAST) ? '0 : div_q + 1'b1);
  assign inc_res     = bcd_inc(BCD_W'(score_q), SCORE_DIGITS);
  assign score_d     = (step_d && crossing) ? inc_res[SCORE_W-1:0] : score_q;
  assign wrap_d      = step_d && crossing && inc_res[BCD_W];
  assign rd_hit      = (rd_idx < N_PIPES_IDX);
  assign unused_bits = ^{inc_res, lfsr_q};

  // Scroll or respawn every slot on a step and flag the pipe whose trailing edge passes the bird.
  always_comb begin
    logic [X_W:0] x_old;
    logic [X_W:0] x_new;
    x_old       = '0;
    x_new       = '0;
    any_respawn = 1'b0;
    crossing    = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      slot_d[i] = slot_q[i];
      x_old     = {1'b0, slot_q[i].x};
      if (x_old >= SPEED_X) begin
        x_new = x_old - SPEED_X;
      end else begin
        x_new = x_old + RESPAWN_ADD;
      end
      x_new = {1'b0, x_new[X_W-1:0]};
      if (step_d) begin
        slot_d[i].x = x_new[X_W-1:0];
        if (x_old < SPEED_X) begin
          slot_d[i].gap = lfsr_q[GAP_W-1:0] ^ GAP_W'(i);
          any_respawn   = 1'b1;
        end
        if ((x_old + PIPE_W_X > BIRD_X_X) && (x_new + PIPE_W_X <= BIRD_X_X)) begin
          crossing = 1'b1;
        end
      end
    end
  end

  // Track state and read port; clear restarts like reset, the read port samples pre-update slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PIPES; i++) slot_q[i] <= init_slot(i);
      div_q      <= '0;
      score_q    <= '0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      rd_x_q     <= '0;
      rd_gap_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_PIPES; i++) slot_q[i] <= init_slot(i);
      div_q      <= '0;
      score_q    <= '0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      rd_x_q     <= '0;
      rd_gap_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_PIPES; i++) slot_q[i] <= slot_d[i];
      div_q      <= div_d;
      score_q    <= score_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      rd_x_q     <= rd_hit ? slot_q[rd_idx[IDX_W-1:0]].x : '0;
      rd_gap_q   <= rd_hit ? slot_q[rd_idx[IDX_W-1:0]].gap : '0;
      rd_valid_q <= rd_hit;
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_gap     = rd_gap_q;
  assign rd_valid   = rd_valid_q;
  assign step       = step_q;
  assign Score      = score_q;
  assign score_wrap = wrap_q;

endmodule

// File: tb/tb_pipe_track_ram.sv
// tb/tb_pipe_track_ram.sv - self-checking bench for pipe_track_ram
module tb_pipe_track_ram;

  localparam int N    = 4;
  localparam int DIVM = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        count_EN = 1'b0;
  logic        clear    = 1'b0;
  logic [2:0]  rd_idx   = 3'd0;
  logic [10:0] rd_x;
  logic [1:0]  rd_gap;
  logic        rd_valid;
  logic        step;
  logic [7:0]  Score;
  logic        score_wrap;

  pipe_track_ram dut (
    .clk       (clk),
    .reset     (reset),
    .count_EN  (count_EN),
    .clear     (clear),
    .rd_idx    (rd_idx),
    .rd_x      (rd_x),
    .rd_gap    (rd_gap),
    .rd_valid  (rd_valid),
    .step      (step),
    .Score     (Score),
    .score_wrap(score_wrap)
  );

  always #5 clk = ~clk;

  typedef struct { logic [10:0] x; logic [1:0] gap; logic valid; } rd_exp_t;
  typedef struct { logic [2:0] idx; logic [10:0] x; logic [1:0] gap; logic valid; } vec_t;

  rd_exp_t     sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          mx[N];
  int          mg[N];
  logic [15:0] mlfsr;
  int          mscore, mdiv, msteps;
  logic        exp_step, exp_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 640 + 180 * i;
      mg[i] = i % 4;
    end
    mlfsr  = 16'hACE1;
    mscore = 0;
    mdiv   = 0;
    msteps = 0;
  endtask

  // Advance the reference model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    int   o, n, hit;
    logic any, fb;
    exp_step = 1'b0;
    exp_wrap = 1'b0;
    if (clear) begin
      model_reset();
    end else if (count_EN) begin
      if (mdiv != DIVM - 1) begin
        mdiv++;
      end else begin
        mdiv     = 0;
        exp_step = 1'b1;
        msteps++;
        any = 1'b0;
        hit = 0;
        for (int i = 0; i < N; i++) begin
          o = mx[i];
          if (o >= 2) begin
            n = o - 2;
          end else begin
            n     = o + N * 180 - 2;
            mg[i] = int'(mlfsr[1:0]) ^ i;
            any   = 1'b1;
          end
          if ((o + 40 > 160) && (n + 40 <= 160)) hit++;
          mx[i] = n;
        end
        chk("crossings_per_step_le1", 32'(hit > 1), 32'(0));
        if (any) begin
          fb    = mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5];
          mlfsr = {fb, mlfsr[15:1]};
        end
        if (hit > 0) begin
          mscore = (mscore + 1) % 100;
          if (mscore == 0) exp_wrap = 1'b1;
        end
      end
    end
  endtask

  // One clock: push the read expectation, step the model, then compare after the edge.
  task automatic cycle();
    rd_exp_t e;
    if (clear) begin
      e.x = '0; e.gap = '0; e.valid = 1'b0;
    end else begin
      e.valid = (rd_idx < 3'(N));
      e.x     = e.valid ? 11'(mx[rd_idx[1:0]]) : 11'd0;
      e.gap   = e.valid ? 2'(mg[rd_idx[1:0]]) : 2'd0;
    end
    sb.push_back(e);
    model_edge();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rd_x", 32'(rd_x), 32'(e.x));
    chk("rd_gap", 32'(rd_gap), 32'(e.gap));
    chk("rd_valid", 32'(rd_valid), 32'(e.valid));
    chk("step", 32'(step), 32'(exp_step));
    chk("Score", 32'(Score), 32'(to_bcd(mscore)));
    chk("score_wrap", 32'(score_wrap), 32'(exp_wrap));
  endtask

  task automatic run_steps(input int target);
    int budget;
    budget = (target - msteps) * DIVM + 8;
    for (int c = 0; c < budget && msteps < target; c++) begin
      rd_idx = 3'(c);
      cycle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog no summary reached by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   nst;
    vecs[0] = '{3'd0, 11'd640,  2'd0, 1'b1};
    vecs[1] = '{3'd1, 11'd820,  2'd1, 1'b1};
    vecs[2] = '{3'd2, 11'd1000, 2'd2, 1'b1};
    vecs[3] = '{3'd3, 11'd1180, 2'd3, 1'b1};
    vecs[4] = '{3'd4, 11'd0,    2'd0, 1'b0};
    vecs[5] = '{3'd5, 11'd0,    2'd0, 1'b0};
    vecs[6] = '{3'd6, 11'd0,    2'd0, 1'b0};
    vecs[7] = '{3'd7, 11'd0,    2'd0, 1'b0};
    model_reset();
    exp_step = 1'b0;
    exp_wrap = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_Score", 32'(Score), 32'(0));
    chk("reset_step", 32'(step), 32'(0));
    chk("reset_wrap", 32'(score_wrap), 32'(0));
    chk("reset_rd_valid", 32'(rd_valid), 32'(0));
    chk("reset_rd_x", 32'(rd_x), 32'(0));
    chk("reset_rd_gap", 32'(rd_gap), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 8; k++) begin
      rd_idx = vecs[k].idx;
      cycle();
      chk("tbl_rd_x", 32'(rd_x), 32'(vecs[k].x));
      chk("tbl_rd_gap", 32'(rd_gap), 32'(vecs[k].gap));
      chk("tbl_rd_valid", 32'(rd_valid), 32'(vecs[k].valid));
    end

    count_EN = 1'b1;
    run_steps(10);
    rd_idx = 3'd0;
    cycle();
    chk("x0_after_10_steps", 32'(rd_x), 32'(620));

    run_steps(259);
    chk("score_before_step260", 32'(Score), 32'(0));
    run_steps(260);
    chk("score_at_step260", 32'(Score), 32'h01);
    rd_idx = 3'd0;
    cycle();
    chk("x0_at_step260", 32'(rd_x), 32'(120));

    run_steps(320);
    rd_idx = 3'd0;
    cycle();
    chk("x0_at_step320", 32'(rd_x), 32'(0));
    run_steps(321);
    rd_idx = 3'd0;
    cycle();
    chk("x0_respawn", 32'(rd_x), 32'(718));
    chk("gap0_respawn", 32'(rd_gap), 32'(1));

    run_steps(440);
    chk("score_at_step440", 32'(Score), 32'h03);

    count_EN = 1'b0;
    nst = 0;
    for (int c = 0; c < 100; c++) begin
      rd_idx = 3'(c);
      cycle();
      if (step) nst++;
    end
    chk("freeze_no_steps", 32'(nst), 32'(0));
    chk("freeze_score", 32'(Score), 32'h03);
    count_EN = 1'b1;

    for (int c = 0; c < 8 && mdiv != DIVM - 1; c++) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clear_step", 32'(step), 32'(0));
    chk("clear_score", 32'(Score), 32'(0));
    count_EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rd_idx = vecs[k].idx;
      cycle();
      chk("clear_tbl_rd_x", 32'(rd_x), 32'(vecs[k].x));
      chk("clear_tbl_rd_gap", 32'(rd_gap), 32'(vecs[k].gap));
    end
    count_EN = 1'b1;

    run_steps(9169);
    chk("score_99", 32'(Score), 32'h99);
    run_steps(9170);
    chk("score_wrapped", 32'(Score), 32'h00);
    chk("score_wrap_pulse", 32'(score_wrap), 32'(1));
    rd_idx = 3'd4;
    cycle();
    chk("score_wrap_one_cycle", 32'(score_wrap), 32'(0));
    chk("oor_rd_valid", 32'(rd_valid), 32'(0));
    chk("oor_rd_x", 32'(rd_x), 32'(0));

    run_steps(9260);
    chk("score_after_wrap", 32'(Score), 32'h01);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_score", 32'(Score), 32'(0));
    chk("async_reset_step", 32'(step), 32'(0));
    chk("async_reset_rd_valid", 32'(rd_valid), 32'(0));
    model_reset();
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd_idx = vecs[k].idx;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
